// File: rtl/eq2_sop_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | eq2_sop_if : operand/result bundle for the eq2_sop compare element    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface eq2_sop_if #(
    parameter int CNT_W = 16
);
    logic [1:0]       a;
    logic [1:0]       b;
    logic             en;
    logic             clr;
    logic             aeqb;
    logic             aeqb_q;
    logic [CNT_W-1:0] eq_cnt;
    logic [CNT_W-1:0] neq_cnt;
    logic             neq_seen;
    logic [3:0]       first_neq;

    modport master (
        output a, b, en, clr,
        input  aeqb, aeqb_q, eq_cnt, neq_cnt, neq_seen, first_neq
    );

    modport slave (
        input  a, b, en, clr,
        output aeqb, aeqb_q, eq_cnt, neq_cnt, neq_seen, first_neq
    );
endinterface
`default_nettype wire

// File: rtl/eq2_sop.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | eq2_sop : 2-bit SOP equality comparator with saturating statistics    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module eq2_sop #(
    parameter int CNT_W = 16
) (
    input  wire logic  clk,
    input  wire logic  reset_n,
    eq2_sop_if.slave   bus
);
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             w_aeqb;
    logic             r_aeqb_q;
    logic [CNT_W-1:0] r_eq_cnt;
    logic [CNT_W-1:0] r_neq_cnt;
    logic             r_neq_seen;
    logic [3:0]       r_first_neq;

    // Four equal minterms; clock-independent so it works with clk stopped.
    assign w_aeqb = (~bus.a[1] & ~bus.a[0] & ~bus.b[1] & ~bus.b[0])
                  | (~bus.a[1] &  bus.a[0] & ~bus.b[1] &  bus.b[0])
                  | ( bus.a[1] & ~bus.a[0] &  bus.b[1] & ~bus.b[0])
                  | ( bus.a[1] &  bus.a[0] &  bus.b[1] &  bus.b[0]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_aeqb_q    <= 1'b0;
            r_eq_cnt    <= '0;
            r_neq_cnt   <= '0;
            r_neq_seen  <= 1'b0;
            r_first_neq <= 4'b0000;
        end else if (bus.clr) begin
            r_aeqb_q    <= 1'b0;
            r_eq_cnt    <= '0;
            r_neq_cnt   <= '0;
            r_neq_seen  <= 1'b0;
            r_first_neq <= 4'b0000;
        end else if (bus.en) begin
            r_aeqb_q <= w_aeqb;
            if (w_aeqb) begin
                if (r_eq_cnt != C_CNT_MAX) begin
                    r_eq_cnt <= r_eq_cnt + C_CNT_ONE;
                end
            end else begin
                if (r_neq_cnt != C_CNT_MAX) begin
                    r_neq_cnt <= r_neq_cnt + C_CNT_ONE;
                end
                if (!r_neq_seen) begin
                    r_neq_seen  <= 1'b1;
                    r_first_neq <= {bus.a, bus.b};
                end
            end
        end
    end

    assign bus.aeqb      = w_aeqb;
    assign bus.aeqb_q    = r_aeqb_q;
    assign bus.eq_cnt    = r_eq_cnt;
    assign bus.neq_cnt   = r_neq_cnt;
    assign bus.neq_seen  = r_neq_seen;
    assign bus.first_neq = r_first_neq;
endmodule
`default_nettype wire

// File: tb/tb_eq2_sop.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_eq2_sop : scoreboard bench for eq2_sop (16-bit and 4-bit counters) |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_eq2_sop;
    logic clk;
    logic clk_on;
    logic reset_n;

    eq2_sop_if #(.CNT_W(16)) bus16 ();
    eq2_sop_if #(.CNT_W(4))  bus4  ();

    eq2_sop #(.CNT_W(16)) dut16 (.clk(clk), .reset_n(reset_n), .bus(bus16.slave));
    eq2_sop #(.CNT_W(4))  dut4  (.clk(clk), .reset_n(reset_n), .bus(bus4.slave));

    assign bus4.a   = bus16.a;
    assign bus4.b   = bus16.b;
    assign bus4.en  = bus16.en;
    assign bus4.clr = bus16.clr;

    typedef struct packed {
        logic        q;
        logic [15:0] eq16;
        logic [15:0] neq16;
        logic [3:0]  eq4;
        logic [3:0]  neq4;
        logic        seen;
        logic [3:0]  first;
    } exp_t;

    exp_t sb[$];
    exp_t m;
    int   total = 0;
    int   bad   = 0;

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_on) clk = ~clk;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected snapshot per clock edge, compared mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_aeqb_q",    {31'd0, bus16.aeqb_q},   {31'd0, e.q});
            chk("sb_eq16",      {16'd0, bus16.eq_cnt},   {16'd0, e.eq16});
            chk("sb_neq16",     {16'd0, bus16.neq_cnt},  {16'd0, e.neq16});
            chk("sb_eq4",       {28'd0, bus4.eq_cnt},    {28'd0, e.eq4});
            chk("sb_neq4",      {28'd0, bus4.neq_cnt},   {28'd0, e.neq4});
            chk("sb_neq_seen",  {31'd0, bus16.neq_seen}, {31'd0, e.seen});
            chk("sb_first_neq", {28'd0, bus16.first_neq},{28'd0, e.first});
        end
    end

    task automatic model_zero();
        m = '0;
    endtask

    task automatic step(input logic [1:0] ta, input logic [1:0] tb_v,
                        input logic ten, input logic tclr);
        bus16.a   = ta;
        bus16.b   = tb_v;
        bus16.en  = ten;
        bus16.clr = tclr;
        @(posedge clk);
        if (tclr) begin
            model_zero();
        end else if (ten) begin
            m.q = (ta == tb_v);
            if (ta == tb_v) begin
                if (m.eq16 != 16'hFFFF) m.eq16 = m.eq16 + 16'd1;
                if (m.eq4  != 4'hF)     m.eq4  = m.eq4 + 4'd1;
            end else begin
                if (m.neq16 != 16'hFFFF) m.neq16 = m.neq16 + 16'd1;
                if (m.neq4  != 4'hF)     m.neq4  = m.neq4 + 4'd1;
                if (!m.seen) begin
                    m.seen  = 1'b1;
                    m.first = {ta, tb_v};
                end
            end
        end
        sb.push_back(m);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] v;
        logic [1:0] va [8];
        logic [1:0] vb [8];
        va = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        vb = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd0};
        model_zero();
        clk_on    = 1'b0;
        reset_n   = 1'b0;
        bus16.a   = 2'd0;
        bus16.b   = 2'd0;
        bus16.en  = 1'b0;
        bus16.clr = 1'b0;
        #20;
        chk("rst_aeqb_q",    {31'd0, bus16.aeqb_q},    32'd0);
        chk("rst_eq_cnt",    {16'd0, bus16.eq_cnt},    32'd0);
        chk("rst_neq_cnt",   {16'd0, bus16.neq_cnt},   32'd0);
        chk("rst_neq_seen",  {31'd0, bus16.neq_seen},  32'd0);
        chk("rst_first_neq", {28'd0, bus16.first_neq}, 32'd0);

        // Combinational sweep with the clock stopped
        for (int i = 0; i < 16; i++) begin
            v = i[3:0];
            bus16.a = v[3:2];
            bus16.b = v[1:0];
            #200;
            chk($sformatf("comb_%04b", v), {31'd0, bus16.aeqb},
                (i == 0 || i == 5 || i == 10 || i == 15) ? 32'd1 : 32'd0);
        end

        reset_n = 1'b1;
        clk_on  = 1'b1;
        settle();

        for (int i = 0; i < 8; i++) step(va[i], vb[i], 1'b1, 1'b0);
        settle();
        chk("vec_eq_cnt",    {16'd0, bus16.eq_cnt},    32'd4);
        chk("vec_neq_cnt",   {16'd0, bus16.neq_cnt},   32'd4);
        chk("vec_neq_seen",  {31'd0, bus16.neq_seen},  32'd1);
        chk("vec_first_neq", {28'd0, bus16.first_neq}, 32'h1);

        step(2'd3, 2'd0, 1'b1, 1'b1);
        settle();
        chk("clr_eq_cnt",    {16'd0, bus16.eq_cnt},    32'd0);
        chk("clr_neq_cnt",   {16'd0, bus16.neq_cnt},   32'd0);
        chk("clr_neq_seen",  {31'd0, bus16.neq_seen},  32'd0);
        chk("clr_first_neq", {28'd0, bus16.first_neq}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            step(2'd2, 2'd2, 1'b0, 1'b0);
            chk("gate_aeqb", {31'd0, bus16.aeqb}, 32'd1);
        end
        chk("gate_eq_cnt", {16'd0, bus16.eq_cnt}, 32'd0);
        chk("gate_aeqb_q", {31'd0, bus16.aeqb_q}, 32'd0);
        step(2'd2, 2'd2, 1'b1, 1'b0);
        settle();
        chk("en_eq_cnt", {16'd0, bus16.eq_cnt}, 32'd1);
        chk("en_aeqb_q", {31'd0, bus16.aeqb_q}, 32'd1);

        // Asynchronous reset mid-cycle after three counted mismatches
        step(2'd0, 2'd0, 1'b0, 1'b1);
        step(2'd0, 2'd1, 1'b1, 1'b0);
        step(2'd1, 2'd2, 1'b1, 1'b0);
        step(2'd3, 2'd0, 1'b1, 1'b0);
        settle();
        chk("pre_rst_neq_cnt", {16'd0, bus16.neq_cnt}, 32'd3);
        bus16.en = 1'b0;
        reset_n  = 1'b0;
        #1;
        model_zero();
        chk("arst_neq_cnt",  {16'd0, bus16.neq_cnt},  32'd0);
        chk("arst_neq_seen", {31'd0, bus16.neq_seen}, 32'd0);
        chk("arst_neq4",     {28'd0, bus4.neq_cnt},   32'd0);
        bus16.a = 2'd1; bus16.b = 2'd1;
        #1;
        chk("arst_aeqb_eq", {31'd0, bus16.aeqb}, 32'd1);
        bus16.a = 2'd1; bus16.b = 2'd2;
        #1;
        chk("arst_aeqb_ne", {31'd0, bus16.aeqb}, 32'd0);
        step(2'd1, 2'd2, 1'b1, 1'b0);
        m = '0;
        sb.delete(sb.size() - 1);
        sb.push_back(m);
        reset_n = 1'b1;

        // Saturation: 4-bit counter pins at 15, 16-bit keeps counting
        step(2'd0, 2'd0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(2'd1, 2'd1, 1'b1, 1'b0);
        settle();
        chk("sat_eq4",   {28'd0, bus4.eq_cnt},   32'd15);
        chk("sat_neq4",  {28'd0, bus4.neq_cnt},  32'd0);
        chk("sat_eq16",  {16'd0, bus16.eq_cnt},  32'd20);
        step(2'd1, 2'd1, 1'b1, 1'b0);
        step(2'd2, 2'd1, 1'b1, 1'b0);
        settle();
        chk("sat_hold_eq4", {28'd0, bus4.eq_cnt},  32'd15);
        chk("sat_neq4_inc", {28'd0, bus4.neq_cnt}, 32'd1);
        chk("sat_first",    {28'd0, bus4.first_neq}, 32'h9);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
`default_nettype wire
